// File: rtl/scalar_loop_ctrl.sv
// scalar_loop_ctrl: sequences scalar-register ops over a 2-D (i,j) sweep and hands points to the datapath.
// Optional macro WOM_STRIDE_EN inserts a WOM step (INC_WOM, o_wr_mul_pos) after each point.
module scalar_loop_ctrl #(
    parameter int CW    = 8,
    parameter int IMM_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_stall,
    input  logic [CW-1:0]    i_rows_cfg,
    input  logic [CW-1:0]    i_cols_cfg,
    input  logic             i_body_ack,
    output logic [2:0]       o_sca_reg_op,
    output logic [IMM_W-1:0] o_imm,
    output logic             o_body_req,
    output logic [CW-1:0]    o_i_idx,
    output logic [CW-1:0]    o_j_idx,
    output logic             o_busy,
`ifdef WOM_STRIDE_EN
    output logic             o_wr_mul_pos,
`endif
    output logic             o_done
);
    localparam logic [2:0] OP_INC_I   = 3'b000;
    localparam logic [2:0] OP_INC_J   = 3'b001;
    localparam logic [2:0] OP_LOAD_N  = 3'b010;
    localparam logic [2:0] OP_RST_I   = 3'b011;
    localparam logic [2:0] OP_RST_J   = 3'b100;
    localparam logic [2:0] OP_INC_WOM = 3'b101;
    localparam logic [2:0] OP_HOLD    = 3'b111;
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR_I, S_CLR_J, S_BODY, S_WOM, S_NEXT, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_rows, r_cols, r_i, r_j;
    logic [CW-1:0] w_i_nxt, w_j_nxt;
    logic [2:0]    w_op;
    logic          w_abort, w_hold, w_j_more, w_i_more;

    // abort only matters inside a sweep; it outranks stall
    assign w_abort  = i_abort && (r_state != S_IDLE);
    assign w_hold   = i_stall || w_abort;
    assign w_j_more = r_j < (r_cols - ONE);
    assign w_i_more = r_i < (r_rows - ONE);

    always_comb begin
        w_next  = r_state;
        w_op    = OP_HOLD;
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_next = (i_rows_cfg == '0 || i_cols_cfg == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                w_op   = OP_LOAD_N;
                w_next = S_CLR_I;
            end
            S_CLR_I: begin
                w_op    = OP_RST_I;
                w_i_nxt = '0;
                w_next  = S_CLR_J;
            end
            S_CLR_J: begin
                w_op    = OP_RST_J;
                w_j_nxt = '0;
                w_next  = S_BODY;
            end
            S_BODY: begin
`ifdef WOM_STRIDE_EN
                if (i_body_ack) w_next = S_WOM;
`else
                if (i_body_ack) w_next = S_NEXT;
`endif
            end
            S_WOM: begin
                w_op   = OP_INC_WOM;
                w_next = S_NEXT;
            end
            S_NEXT: begin
                if (w_j_more) begin
                    w_op    = OP_INC_J;
                    w_j_nxt = r_j + ONE;
                    w_next  = S_BODY;
                end else if (w_i_more) begin
                    w_op    = OP_INC_I;
                    w_i_nxt = r_i + ONE;
                    w_next  = S_CLR_J;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next  = S_IDLE;
            w_i_nxt = '0;
            w_j_nxt = '0;
        end else if (i_stall) begin
            w_next  = r_state;
            w_i_nxt = r_i;
            w_j_nxt = r_j;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rows  <= '0;
            r_cols  <= '0;
            r_i     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_next;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            if (r_state == S_IDLE && i_start && !i_stall) begin
                r_rows <= i_rows_cfg;
                r_cols <= i_cols_cfg;
            end
        end
    end

    assign o_sca_reg_op = w_hold ? OP_HOLD : w_op;
    assign o_imm        = (r_state == S_LOAD && !w_hold) ? IMM_W'(r_cols) : '0;
    assign o_body_req   = (r_state == S_BODY) && !w_hold;
    assign o_done       = (r_state == S_DONE) && !w_hold;
    assign o_busy       = r_state != S_IDLE;
    assign o_i_idx      = r_i;
    assign o_j_idx      = r_j;
`ifdef WOM_STRIDE_EN
    assign o_wr_mul_pos = (r_state == S_WOM) && !w_hold;
`endif
endmodule
